state_receiver: RTL and testbench
=================================

# state_receiver

Deserializing receiver for the inter-FPGA link. It consumes the three-wire serial stream (data, clock, select) that the opponent board's `state_transmitter` drives. It rebuilds the opponent's `data_t` word and scored bit, and presents them to the game FSM as a single-cycle valid pulse. It also derives `opponent_started_out` from the idle level of the link clock, which is the handshake the transmitter encodes by holding its clock line low or high.

## Interface
Parameters:
- `DATA_WIDTH`, default `$bits(data_t)+1` (90): frame length in bits, `{data_t, scored}`.
- `SYNC_STAGES`, default 2: flip-flop stages on each asynchronous input.
- `TIMEOUT_CYCLES`, default 400: maximum `clk_pixel_in` cycles between link-clock rising edges inside a frame.
- `START_DETECT_CYCLES`, default 1024: consecutive high cycles of an idle link clock that mean the peer has started.

Ports (one clock; reset is asynchronous and active-high):
- `clk_pixel_in`  in  1  pixel clock, the only clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `data_in`  in  1  serial data from peer, asynchronous.
- `data_clk_in`  in  1  link clock from peer, asynchronous.
- `sel_in`  in  1  frame select from peer, active-low, asynchronous.
- `opponent_data_out`  out  `$bits(data_t)`  last good frame payload.
- `opponent_scored_out`  out  1  last good frame scored bit.
- `opponent_data_valid_out`  out  1  one-cycle pulse when a new good frame is latched.
- `frame_error_out`  out  1  one-cycle pulse when a frame is rejected.
- `opponent_started_out`  out  1  the peer has started.

## Operation
- Inputs pass through `SYNC_STAGES` synchronizers, then one edge-detect register each. All logic below uses the synchronized signals.
- Frame format: MSB first. Bit `DATA_WIDTH-1` is `data_t[MSB]`; bit 0 is the scored bit. Data is sampled on the synchronized rising edge of the link clock while `sel` is low.
- FSM states:
  - IDLE: wait for a `sel` falling edge. On that edge, clear the bit counter and the timeout counter, then go to RECV.
  - RECV:
    - On each link-clock rising edge, shift in `data`. The bit counter increments and saturates at `DATA_WIDTH+1`. The timeout counter clears.
    - If the timeout counter reaches `TIMEOUT_CYCLES`, go to FLUSH.
    - On a `sel` rising edge, go to CHECK.
  - CHECK (one cycle):
    - If count equals `DATA_WIDTH`, latch the payload and scored bit into the outputs and pulse valid.
    - Otherwise, pulse `frame_error_out` and leave the outputs unchanged.
    - Then go to IDLE.
  - FLUSH: pulse `frame_error_out` once on entry, then wait for synchronized `sel` high and go to IDLE. No payload is latched.
- Outputs hold their last good frame until the next good frame; there is no partial update.
- Started detection:
  - Runs only while synchronized `sel` is high.
  - A counter counts consecutive cycles with link clock high. At `START_DETECT_CYCLES`, set `opponent_started_out`.
  - The same counter counts consecutive cycles with the clock low. At `START_DETECT_CYCLES`, clear `opponent_started_out`.
  - Any good frame also sets `opponent_started_out`.
  - The counter saturates and is cleared on every level change.
- Simultaneous `sel` rising edge and link-clock rising edge: the bit is shifted first, then CHECK evaluates the updated count.
- Simultaneous timeout and `sel` rising edge: the `sel` edge wins and the FSM goes to CHECK.
- A `sel` falling edge in FLUSH or CHECK is ignored; the next frame is picked up from IDLE only.

## Timing
- Reset values:
  - FSM in IDLE, all counters 0.
  - `opponent_data_out` = 0, `opponent_scored_out` = 0.
  - `opponent_data_valid_out` = 0, `frame_error_out` = 0, `opponent_started_out` = 0.
  - Synchronizer stages load 1 for `sel` and 0 for the other inputs.
- Reset asserted mid-frame discards the frame with no error pulse.
- Latency: a `sel` rising edge at the pin produces the valid pulse `SYNC_STAGES+2` cycles later (4 at defaults).
- The link bit period must be at least 4 `clk_pixel_in` cycles; the transmitter's period of 100 satisfies this.
- `opponent_data_valid_out` and `frame_error_out` are never high in the same cycle, and each is high for exactly one cycle.

## Configuration
- `STATE_RX_STATS_EN`
  - Defined: adds outputs `frame_count_out` [15:0] and `error_count_out` [15:0]. They increment on valid and error pulses respectively, saturate at 0xFFFF, and reset to 0.
  - Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- `types.svh` holds `data_t` and `location_t`. It also gains `STATE_FRAME_BITS = $bits(data_t)+1`, which is shared with `state_transmitter`.
- One sub-module: `sync_ff` (parameterised depth, single-bit, asynchronous reset value as a parameter). It is instantiated three times.

## Test plan
- Good frame of payload `89'h1_5555_5555_5555_5555_5555`, scored = 1, bit period 100 → valid pulses once 4 cycles after `sel` rises; outputs equal the payload and scored bit; no error pulse.
- Frame truncated to 89 bits → `frame_error_out` pulses once; outputs keep their previous value.
- 91 clock edges inside one `sel` window → error pulse; outputs unchanged.
- Link clock stops mid-frame for 401 cycles with `sel` low → one error pulse; `sel` then rises; a following good frame is accepted.
- Idle link clock held high for 1024 cycles → `opponent_started_out` rises. Clock then held low for 1024 cycles → it falls.
- `rst_in` pulsed at bit 45 of a frame → all outputs return to 0 with no pulses; the next full frame is accepted.

Source files
------------

// File: rtl/state_receiver_pkg.sv
// Shared types for the inter-FPGA state link: payload word, frame length and receiver FSM states.
package state_receiver_pkg;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } location_t;

  typedef struct packed {
    location_t   ball;
    location_t   paddle_self;
    location_t   paddle_peer;
    location_t   ball_velocity;
    logic [4:0]  flags;
  } data_t;

  // Frame is {data_t, scored}; the transmitter uses the same constant.
  localparam int STATE_FRAME_BITS = $bits(data_t) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_FLUSH
  } rx_state_e;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-stage synchronizer with a configurable asynchronous reset value.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_stages;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_stages <= {STAGES{RST_VAL}};
    else       r_stages <= {r_stages[STAGES-2:0], i_d};
  end

  assign o_q = r_stages[STAGES-1];

endmodule

// File: rtl/state_receiver.sv
// Deserializing receiver for the three-wire inter-FPGA state link, plus peer-started detection.
// Optional STATE_RX_STATS_EN adds saturating good-frame and error-frame counters.
module state_receiver
  import state_receiver_pkg::*;
#(
  parameter int DATA_WIDTH          = STATE_FRAME_BITS,
  parameter int SYNC_STAGES         = 2,
  parameter int TIMEOUT_CYCLES      = 400,
  parameter int START_DETECT_CYCLES = 1024
) (
  input  logic  clk_pixel_in,
  input  logic  rst_in,
  input  logic  data_in,
  input  logic  data_clk_in,
  input  logic  sel_in,
  output data_t opponent_data_out,
  output logic  opponent_scored_out,
  output logic  opponent_data_valid_out,
  output logic  frame_error_out,
  output logic  opponent_started_out
`ifdef STATE_RX_STATS_EN
  ,
  output logic [15:0] frame_count_out,
  output logic [15:0] error_count_out
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LVL_W = $clog2(START_DETECT_CYCLES + 1);

  logic w_data_s, w_clk_s, w_sel_s;
  logic r_clk_d, r_sel_d;
  logic w_clk_rise, w_sel_rise, w_sel_fall;

  rx_state_e r_state, w_next;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [TO_W-1:0]       r_timeout;
  logic [LVL_W-1:0]      r_lvl_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  w_good, w_bad;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .i_clk(clk_pixel_in), .i_rst(rst_in), .i_d(data_in), .o_q(w_data_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .i_clk(clk_pixel_in), .i_rst(rst_in), .i_d(data_clk_in), .o_q(w_clk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sel (
    .i_clk(clk_pixel_in), .i_rst(rst_in), .i_d(sel_in), .o_q(w_sel_s));

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      r_clk_d <= 1'b0;
      r_sel_d <= 1'b1;
    end else begin
      r_clk_d <= w_clk_s;
      r_sel_d <= w_sel_s;
    end
  end

  assign w_clk_rise = w_clk_s & ~r_clk_d;
  assign w_sel_rise = w_sel_s & ~r_sel_d;
  assign w_sel_fall = ~w_sel_s & r_sel_d;

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_sel_fall) w_next = S_RECV;
      S_RECV: begin
        // A sel edge in the same cycle as the timeout still closes the frame normally.
        if (w_sel_rise)                                w_next = S_CHECK;
        else if (r_timeout == TO_W'(TIMEOUT_CYCLES))   w_next = S_FLUSH;
      end
      S_CHECK: w_next = S_IDLE;
      S_FLUSH: if (w_sel_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_good = (r_state == S_CHECK) && (r_bit_cnt == CNT_W'(DATA_WIDTH));
    w_bad  = ((r_state == S_CHECK) && !w_good) ||
             ((r_state == S_RECV) && (w_next == S_FLUSH));
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      r_bit_cnt <= '0;
      r_timeout <= '0;
    end else if (r_state == S_IDLE && w_sel_fall) begin
      r_bit_cnt <= '0;
      r_timeout <= '0;
    end else if (r_state == S_RECV) begin
      if (w_clk_rise) begin
        if (r_bit_cnt != CNT_W'(DATA_WIDTH + 1)) r_bit_cnt <= r_bit_cnt + 1'b1;
        r_timeout <= '0;
      end else if (r_timeout != TO_W'(TIMEOUT_CYCLES)) begin
        r_timeout <= r_timeout + 1'b1;
      end
    end
  end

  // NOTE: the shift register has no reset; it is only read once a full count has arrived.
  always_ff @(posedge clk_pixel_in) begin
    if (r_state == S_RECV && w_clk_rise) r_shift <= {r_shift[DATA_WIDTH-2:0], w_data_s};
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      opponent_data_out       <= '0;
      opponent_scored_out     <= 1'b0;
      opponent_data_valid_out <= 1'b0;
      frame_error_out         <= 1'b0;
    end else begin
      opponent_data_valid_out <= w_good;
      frame_error_out         <= w_bad;
      if (w_good) begin
        opponent_data_out   <= data_t'(r_shift[DATA_WIDTH-1:1]);
        opponent_scored_out <= r_shift[0];
      end
    end
  end

  // Idle link-clock level encodes the peer's started flag; only meaningful between frames.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      r_lvl_cnt            <= '0;
      opponent_started_out <= 1'b0;
    end else begin
      if (!w_sel_s || (w_clk_s != r_clk_d))                 r_lvl_cnt <= '0;
      else if (r_lvl_cnt != LVL_W'(START_DETECT_CYCLES))    r_lvl_cnt <= r_lvl_cnt + 1'b1;

      if (w_good)
        opponent_started_out <= 1'b1;
      else if (w_sel_s && r_lvl_cnt == LVL_W'(START_DETECT_CYCLES))
        opponent_started_out <= r_clk_d;
    end
  end

`ifdef STATE_RX_STATS_EN
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      frame_count_out <= '0;
      error_count_out <= '0;
    end else begin
      if (opponent_data_valid_out && frame_count_out != 16'hFFFF) frame_count_out <= frame_count_out + 1'b1;
      if (frame_error_out && error_count_out != 16'hFFFF)         error_count_out <= error_count_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_state_receiver.sv
// Directed bench for state_receiver: scoreboarded frames, latency, started detection, timeout and reset.
module tb_state_receiver;
  import state_receiver_pkg::*;

  localparam int FW = STATE_FRAME_BITS;

  logic  clk = 1'b0;
  logic  rst;
  logic  data_pin, clk_pin, sel_pin;
  data_t opp_data;
  logic  opp_scored, opp_valid, frm_err, opp_started;
`ifdef STATE_RX_STATS_EN
  logic [15:0] frame_count, error_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit           is_good;
    logic [FW-2:0] data;
    logic         scored;
  } exp_t;
  exp_t sb[$];
  logic [FW-2:0] last_data   = '0;
  logic          last_scored = 1'b0;

  always #5 clk = ~clk;

  state_receiver dut (
    .clk_pixel_in            (clk),
    .rst_in                  (rst),
    .data_in                 (data_pin),
    .data_clk_in             (clk_pin),
    .sel_in                  (sel_pin),
    .opponent_data_out       (opp_data),
    .opponent_scored_out     (opp_scored),
    .opponent_data_valid_out (opp_valid),
    .frame_error_out         (frm_err),
    .opponent_started_out    (opp_started)
`ifdef STATE_RX_STATS_EN
    ,
    .frame_count_out         (frame_count),
    .error_count_out         (error_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every valid/error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (opp_valid || frm_err)) begin
      exp_t e;
      check("pulse_exclusive", {opp_valid, frm_err} == 2'b11, 1'b0);
      check("pulse_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pulse_kind", opp_valid, e.is_good);
        if (e.is_good) begin
          last_data   = e.data;
          last_scored = e.scored;
        end
        check("out_data", opp_data, last_data);
        check("out_scored", opp_scored, last_scored);
      end
    end
  end

  task automatic push(input bit good, input logic [FW-1:0] f);
    exp_t e;
    e.is_good = good;
    e.data    = f[FW-1:1];
    e.scored  = f[0];
    sb.push_back(e);
  endtask

  // Drives nbits link-clock periods MSB first; optionally closes the frame by raising sel.
  task automatic send_frame(input logic [FW-1:0] f, input int nbits, input int half, input bit close);
    logic [FW-1:0] v;
    v = f;
    @(negedge clk);
    sel_pin = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      data_pin = (i < FW) ? v[FW-1-i] : 1'b0;
      clk_pin  = 1'b0;
      repeat (half) @(negedge clk);
      clk_pin  = 1'b1;
      repeat (half) @(negedge clk);
    end
    if (close) begin
      clk_pin = 1'b0;
      repeat (half) @(negedge clk);
      sel_pin = 1'b1;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    check(tag, sb.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[FW-1:0];
  endfunction

  initial begin
    logic [FW-1:0] f;
    rst = 1'b1; data_pin = 1'b0; clk_pin = 1'b0; sel_pin = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", opp_data, 0);
    check("rst_scored", opp_scored, 0);
    check("rst_valid", opp_valid, 0);
    check("rst_error", frm_err, 0);
    check("rst_started", opp_started, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Started detection from the idle link-clock level.
    clk_pin = 1'b1;
    repeat (1000) @(negedge clk);
    check("started_early", opp_started, 0);
    repeat (40) @(negedge clk);
    check("started_high", opp_started, 1);
    clk_pin = 1'b0;
    repeat (1000) @(negedge clk);
    check("started_hold", opp_started, 1);
    repeat (40) @(negedge clk);
    check("started_low", opp_started, 0);

    // Good frame at bit period 100 with exact sel-to-valid latency.
    f = {89'h1_5555_5555_5555_5555_5555, 1'b1};
    push(1'b1, f);
    send_frame(f, FW, 50, 1'b1);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("latency_early", opp_valid, 0);
    end
    @(posedge clk); @(negedge clk);
    check("latency_valid", opp_valid, 1);
    wait_drain("drain_good1");
    check("started_by_frame", opp_started, 1);

    // Truncated and over-long frames are rejected; outputs hold.
    push(1'b0, '0);
    send_frame(rand_frame(), FW - 1, 4, 1'b1);
    wait_drain("drain_short");
    push(1'b0, '0);
    send_frame(rand_frame(), FW + 1, 4, 1'b1);
    wait_drain("drain_long");

    f = rand_frame();
    push(1'b1, f);
    send_frame(f, FW, 4, 1'b1);
    wait_drain("drain_good2");

    // Link clock stalls mid-frame: one error, then recovery.
    push(1'b0, '0);
    send_frame(rand_frame(), 30, 4, 1'b0);
    clk_pin = 1'b0;
    repeat (420) @(negedge clk);
    check("timeout_pulse", sb.size(), 0);
    sel_pin = 1'b1;
    repeat (10) @(negedge clk);
    f = rand_frame();
    push(1'b1, f);
    send_frame(f, FW, 4, 1'b1);
    wait_drain("drain_after_timeout");

    // Reset in the middle of a frame.
    send_frame(rand_frame(), 45, 4, 1'b0);
    rst = 1'b1; sel_pin = 1'b1; clk_pin = 1'b0;
    last_data = '0; last_scored = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data", opp_data, 0);
    check("midrst_scored", opp_scored, 0);
    check("midrst_started", opp_started, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_pulse", {opp_valid, frm_err}, 0);
    f = rand_frame();
    push(1'b1, f);
    send_frame(f, FW, 4, 1'b1);
    wait_drain("drain_after_reset");
    check("final_data", opp_data, f[FW-1:1]);
    check("final_scored", opp_scored, f[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
